// File: rtl/wb_word_prefetch_pkg.sv
// Shared definitions for the word prefetcher.
//   state_e : block sequencer states (idle, issuing reads, draining the FIFO)
//   clog2   : ceiling log2, sizes FIFO pointers and occupancy counters
package wb_word_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_word_prefetch_fifo_sync.sv
// Synchronous FIFO holding prefetched words.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (storage, pointers, count)
//   flush_i : empties the FIFO; wins over a same-cycle push/pop
//   push_i  : write din_i at the tail
//   din_i   : word to write
//   pop_i   : advance the head (caller guarantees not empty)
//   head_o  : word at the head
//   count_o : registered occupancy
//   empty_o : occupancy is zero
module wb_word_prefetch_fifo_sync
    import wb_word_prefetch_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            din_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o,
    output logic                        empty_o
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/wb_word_prefetch.sv
// Streams a block of LENGTH words out of a synchronous block RAM, address 0
// upward, and presents them one at a time on a fetch/ready/value handshake.
// Reads are issued ahead into a small FIFO, limited by a credit rule so the
// FIFO can never overflow.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   start_i   : pulse; (re)start a block at address 0, aborting any block in progress
//   ram_rd_o  : RAM read enable
//   ram_adr_o : RAM read address
//   ram_dat_i : RAM read data, valid LATENCY cycles after ram_rd_o
//   fetch_i   : downstream request, held until ready_o
//   ready_o   : value_o holds a valid word
//   value_o   : word at the FIFO head
//   busy_o    : block in progress
//   done_o    : pulse on the consume of the last word of a block
module wb_word_prefetch
    import wb_word_prefetch_pkg::*;
#(
    parameter int WIDTH   = 48,
    parameter int ABITS   = 6,
    parameter int LENGTH  = 64,
    parameter int LATENCY = 1,
    parameter int FDEPTH  = 4,
    parameter int DELAY   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              ram_rd_o,
    output logic [ABITS-1:0]  ram_adr_o,
    input  logic [WIDTH-1:0]  ram_dat_i,
    input  logic              fetch_i,
    output logic              ready_o,
    output logic [WIDTH-1:0]  value_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CW  = clog2(FDEPTH + 1);
    localparam int IW  = ABITS + 1;
    localparam int PCW = clog2(LATENCY + 1);

    if (LATENCY < 1 || LATENCY > 2 || FDEPTH < LATENCY + 1 || LENGTH < 1 ||
        LENGTH > (1 << ABITS) || DELAY < 0) begin : g_bad_params
        $error("wb_word_prefetch: unsupported parameter combination");
    end

    state_e             state_q, state_d;
    logic [ABITS-1:0]   adr_q, adr_d;
    logic [IW-1:0]      issued_q, issued_d;
    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;

    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_head;
    logic               fifo_push;
    logic               pop;
    logic [PCW-1:0]     inflight;
    logic               credit;
    logic               last_issue;
    logic               last_pop;

    wb_word_prefetch_fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (FDEPTH)
    ) u_fifo_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (start_i),
        .push_i  (fifo_push),
        .din_i   (ram_dat_i),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign ready_o   = !fifo_empty;
    assign value_o   = fifo_head;
    assign ram_adr_o = adr_q;
    assign pop       = fetch_i && ready_o;
    // The word leaving the latency pipe is the RAM data of that cycle.
    assign fifo_push = vld_pipe_q[LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + PCW'(vld_pipe_q[i]);
        end
    end

    // Conservative credit: a pop in this same cycle is not counted.
    assign credit     = (int'(fifo_count) + int'(inflight)) < FDEPTH;
    assign last_issue = ram_rd_o && (issued_q == IW'(LENGTH - 1));
    assign last_pop   = pop && (fifo_count == CW'(1)) && (inflight == '0);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start always (re)enters RUN, aborting any block.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_i)         state_d = ST_RUN;
                else if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start_i)       state_d = ST_RUN;
                else if (last_pop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs; a read is suppressed in the start cycle since the pipe is flushed.
    always_comb begin
        ram_rd_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy_o   = 1'b1;
                ram_rd_o = !start_i && credit && (issued_q < IW'(LENGTH));
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                done_o = !start_i && last_pop;
            end
            default: ;
        endcase
    end

    // Address holds at LENGTH-1 after the final read so it never runs past the block.
    always_comb begin
        adr_d      = adr_q;
        issued_d   = issued_q;
        vld_pipe_d = '0;
        if (start_i) begin
            adr_d    = '0;
            issued_d = '0;
        end else begin
            vld_pipe_d[0] = ram_rd_o;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
            if (ram_rd_o) begin
                issued_d = issued_q + IW'(1);
                if (!last_issue) begin
                    adr_d = adr_q + ABITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            adr_q      <= '0;
            issued_q   <= '0;
            vld_pipe_q <= '0;
        end else begin
            adr_q      <= adr_d;
            issued_q   <= issued_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

endmodule

// File: tb/tb_wb_word_prefetch.sv
`timescale 1ns/1ps
module tb_wb_word_prefetch;

    localparam int WIDTH  = 48;
    localparam int ABITS  = 6;
    localparam int FDEPTH = 4;
    localparam int NCFG   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // cfg0: LENGTH=4, cfg1: LATENCY=2 LENGTH=64, cfg2: LENGTH=1, cfg3: LENGTH=64
    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int LAT = (g == 1) ? 2 : 1;
        localparam int LEN = (g == 0) ? 4 : ((g == 2) ? 1 : 64);
        localparam int CREDIT_RDS = (LEN < FDEPTH) ? LEN : FDEPTH;
        localparam int AFTER_POP_RDS = (LEN < FDEPTH + 1) ? LEN : FDEPTH + 1;

        logic             rst, start, fetch;
        logic             ram_rd, ready, busy, done;
        logic [ABITS-1:0] ram_adr;
        logic [WIDTH-1:0] ram_dat, value;
        logic [WIDTH-1:0] mem [64];
        logic [WIDTH-1:0] d1 = '0;
        logic [WIDTH-1:0] d2 = '0;
        logic [WIDTH-1:0] exp_q [$];
        logic [WIDTH-1:0] mon_exp;
        int               rd_cnt = 0;
        int               pop_cnt = 0;
        int               ovf_cnt = 0;
        bit               pop_flag = 1'b0;
        bit               blk_done = 1'b0;
        bit               fin = 1'b0;

        wb_word_prefetch #(
            .WIDTH   (WIDTH),
            .ABITS   (ABITS),
            .LENGTH  (LEN),
            .LATENCY (LAT),
            .FDEPTH  (FDEPTH),
            .DELAY   (3)
        ) dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .start_i   (start),
            .ram_rd_o  (ram_rd),
            .ram_adr_o (ram_adr),
            .ram_dat_i (ram_dat),
            .fetch_i   (fetch),
            .ready_o   (ready),
            .value_o   (value),
            .busy_o    (busy),
            .done_o    (done)
        );

        // Synchronous RAM with 1 or 2 cycles of read latency
        always @(posedge clk) begin
            if (ram_rd) d1 <= mem[ram_adr];
            d2 <= d1;
        end
        assign ram_dat = (LAT == 1) ? d1 : d2;

        task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
            check($sformatf("c%0d_%s", g, nm), act, exp);
        endtask

        // Monitor: samples just before each rising edge what that edge will do.
        always @(negedge clk) begin
            #2;
            pop_flag = 1'b0;
            if (!rst) begin
                if (ram_rd) begin
                    ck("rd_adr", 64'(ram_adr) | ((rd_cnt >= LEN) ? 64'h100 : 64'h0), 64'(rd_cnt));
                    rd_cnt++;
                end
                if (fetch && ready) begin
                    pop_flag = 1'b1;
                    if (exp_q.size() == 0) begin
                        ck("ready_no_data", ready, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        ck("value", value, mon_exp);
                        ck("done_on_pop", done, (exp_q.size() == 0));
                        if (exp_q.size() == 0) blk_done = 1'b1;
                    end
                    pop_cnt++;
                end else if (done) begin
                    ck("spurious_done", done, 0);
                end
                if (rd_cnt - pop_cnt > FDEPTH) ovf_cnt++;
            end
        end

        task automatic reset_outputs_check(input string tag);
            ck({tag, "_ready"},  ready,   0);
            ck({tag, "_value"},  value,   0);
            ck({tag, "_ram_rd"}, ram_rd,  0);
            ck({tag, "_adr"},    ram_adr, 0);
            ck({tag, "_busy"},   busy,    0);
            ck({tag, "_done"},   done,    0);
        endtask

        task automatic start_block(input bit rand_data);
            @(negedge clk);
            for (int i = 0; i < 64; i++) begin
                mem[i] = rand_data ? WIDTH'({$urandom(), $urandom()}) : WIDTH'(i * 32'h010101);
            end
            exp_q.delete();
            for (int i = 0; i < LEN; i++) exp_q.push_back(mem[i]);
            rd_cnt   = 0;
            pop_cnt  = 0;
            blk_done = 1'b0;
            fetch    = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        // Random fetch; dropped for one cycle after every pop.
        task automatic consume(input int target, input bit to_done);
            bit reached;
            reached = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (to_done ? blk_done : (pop_cnt >= target)) begin
                    fetch   = 1'b0;
                    reached = 1'b1;
                    break;
                end
                if (pop_flag)    fetch = 1'b0;
                else if (!fetch) fetch = ($urandom_range(0, 3) != 0);
            end
            fetch = 1'b0;
            if (!reached) ck("consume_timeout", pop_cnt, to_done ? LEN : target);
        endtask

        task automatic block_end_check(input string tag);
            ck({tag, "_reads"}, rd_cnt,  LEN);
            ck({tag, "_pops"},  pop_cnt, LEN);
            ck({tag, "_busy"},  busy,    0);
            ck({tag, "_adr"},   ram_adr, LEN - 1);
        endtask

        initial begin
            rst   = 1'b1;
            start = 1'b0;
            fetch = 1'b0;
            for (int i = 0; i < 64; i++) mem[i] = '0;
            repeat (2) @(negedge clk);
            reset_outputs_check("rst");
            rst = 1'b0;

            // fetch while idle is held off
            fetch = 1'b1;
            repeat (4) @(negedge clk);
            ck("idle_ready", ready, 0);
            ck("idle_reads", rd_cnt, 0);
            fetch = 1'b0;

            // Block 1: RAM[i] = i*0x010101, no fetch until credit is exhausted
            start_block(1'b0);
            repeat (12) @(negedge clk);
            ck("credit_reads", rd_cnt, CREDIT_RDS);
            ck("credit_busy", busy, 1);
            ck("credit_ready", ready, 1);
            fetch = 1'b1;
            @(negedge clk);
            fetch = 1'b0;
            @(negedge clk);
            ck("read_after_pop", rd_cnt, AFTER_POP_RDS);
            consume(0, 1'b1);
            block_end_check("blk1");

            // Block 2: aborted midway by a new start with fresh RAM contents
            start_block(1'b1);
            consume(LEN / 2, 1'b0);
            start_block(1'b1);
            consume(0, 1'b1);
            block_end_check("abort");

            // Block 3: asynchronous reset between clock edges
            start_block(1'b1);
            consume(LEN / 3, 1'b0);
            @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            reset_outputs_check("async_rst");
            exp_q.delete();
            rd_cnt  = 0;
            pop_cnt = 0;
            fetch   = 1'b0;
            @(negedge clk);
            rst = 1'b0;

            // Block 4: clean restart after reset
            start_block(1'b1);
            consume(0, 1'b1);
            block_end_check("restart");
            ck("no_overflow", ovf_cnt, 0);
            fin = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin;
            if (all_fin) break;
        end
        if (!all_fin) check("global_timeout", all_fin, 1);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
